edge_event_capture: RTL and testbench
=====================================

# edge_event_capture

Parametrised multi-channel edge detector for the PLL/clock-control register space on the AHB clock. Each channel has an optional synchroniser, a programmable glitch filter, a per-channel edge mode (rise/fall/both/off), a one-cycle event pulse, a sticky write-1-to-clear status bit, and a saturating event counter. A masked OR of the sticky bits produces a single interrupt. It replaces single-bit, rise-only, unfiltered edge detection of control bits and PLL lock/status lines.

## Interface

Parameters:
- NUM_CH, 4: number of channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per channel (0 = bypass, for inputs already on i_clk_ahb).
- FILT_W, 4: width of the filter-length field and of each filter counter.
- CNT_W, 8: width of each event counter.

Ports:
- i_clk_ahb  in  1  clock; the only clock.
- i_rstn_ahb  in  1  reset, synchronous, active-low.
- i_sig  in  NUM_CH  monitored inputs; may be asynchronous when SYNC_STAGES>0.
- i_mode  in  2*NUM_CH  per-channel mode; ch n uses bits [2n+1:2n]: 00 off, 01 rise, 10 fall, 11 both.
- i_filt_len  in  FILT_W  filter length L, shared by all channels; 0 = no filtering.
- i_irq_en  in  NUM_CH  per-channel interrupt enable.
- i_clr  in  NUM_CH  sticky clear, one bit per channel, write-1-to-clear pulse.
- i_cnt_clr  in  1  clears all event counters.
- o_pulse  out  NUM_CH  one-cycle pulse per qualified edge.
- o_sticky  out  NUM_CH  sticky event flags.
- o_count  out  NUM_CH*CNT_W  per-channel saturating event counts; ch n uses [CNT_W*(n+1)-1:CNT_W*n].
- o_irq  out  1  |(o_sticky & i_irq_en), registered.

## Operation

- **Synchroniser.** i_sig[n] passes through SYNC_STAGES flops to give s[n].
- **Filtered level f[n].**
  - When s != f: fcnt increments (saturates at all-ones).
  - When s == f: fcnt clears.
  - Commit (f <= s, fcnt <= 0) happens in a mismatch cycle where fcnt >= L.
  - L=0 commits on the first mismatch cycle. A pulse shorter than L+1 cycles at s is ignored.
- **Edges.**
  - Rise = commit with s=1; fall = commit with s=0.
  - Qualified by mode: rise for 01, fall for 10, either for 11, none for 00.
  - f tracks s in every mode, including 00.
- **Qualified edge effects.** o_pulse[n]=1 for exactly one cycle, o_sticky[n] set, count[n] incremented (saturates at 2^CNT_W-1).
- **Startup suppression.**
  - For SYNC_STAGES+1 cycles after reset release, f loads s directly and all edges are discarded.
  - An input held high through reset therefore produces no rise event.
- **Simultaneous events.**
  - Set and i_clr on the same channel in one cycle: sticky stays 1.
  - Qualified edge with i_cnt_clr in the same cycle: count becomes 1.
  - i_cnt_clr alone: count becomes 0.
- **Mid-operation changes.**
  - i_mode and i_filt_len changes take effect on the next clock edge.
  - If L shrinks below a running fcnt, the next mismatch cycle commits.
- **Reset (synchronous, active-low, also mid-operation).** Sync flops, f, fcnt, o_pulse, o_sticky, o_count, o_irq all 0; the startup suppression counter restarts.

## Timing

- Edge 0 = first i_clk_ahb edge sampling the new i_sig level, input held stable.
- o_pulse is high during the cycle after edge SYNC_STAGES+L.
- o_sticky and o_count update on that same edge.
- o_irq follows one edge later.
- i_clr and i_cnt_clr act on the next edge; status reads are valid the cycle after.
- Back-to-back edges:
  - With L=0 and SYNC_STAGES=0, an input toggling every cycle yields a pulse every cycle in mode 11.
  - In mode 01 the same input yields a pulse every other cycle.
- No combinational input-to-output paths.

## Structure

- Package edge_cap_pkg:
  - typedef enum logic [1:0] edge_mode_e: EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH.
  - Default parameter constants.
- Sub-module edge_cap_chan, one instance per channel via generate. It holds the synchroniser, filter, detect, sticky and counter for one channel.
- Top level holds the startup suppression counter, the generate loop and the o_irq reduction.

## Test plan

- **Basic rise.** NUM_CH=4, SYNC_STAGES=2, L=0, ch0 mode 01; raise i_sig[0] at edge 10 -> o_pulse[0] high after edge 12 only, sticky[0]=1, count[0]=1, o_irq=1 one edge later with i_irq_en[0]=1.
- **Glitch filter.** L=3; 3-cycle high glitch on ch1 (mode 11) -> no pulse. 4-cycle high -> one rise pulse, and the later fall gives a second pulse, count=2.
- **Modes.** Same toggle pattern on ch0..3 with modes 00/01/10/11 -> counts 0/N/N/2N for N full periods; all f values end equal to the input.
- **Clear priority.** i_clr[2] in the same cycle as a ch2 edge -> sticky[2] stays 1. i_cnt_clr with an edge -> count=1. 300 edges with CNT_W=8 -> count saturates at 255.
- **Reset.** i_sig all-ones held through reset -> no pulses after release. Reset asserted mid-filter (fcnt=2) -> all outputs 0 on the next edge, and there is no stale commit afterwards.

Source files
------------

// File: rtl/edge_cap_pkg.sv
// Shared types and default sizing for the PLL/clock-control edge capture block.
package edge_cap_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_W      = 4;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/edge_cap_chan.sv
// One capture channel: synchroniser, glitch filter, edge qualify, sticky flag
// and saturating event counter.
module edge_cap_chan
    import edge_cap_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_W      = DEF_FILT_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              sig_i,
    input  logic [1:0]        mode_i,
    input  logic [FILT_W-1:0] filt_len_i,
    input  logic              suppress_i,
    input  logic              clr_i,
    input  logic              cnt_clr_i,
    output logic              pulse_o,
    output logic              sticky_o,
    output logic [CNT_W-1:0]  count_o
);

    logic s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = sig_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk_i) begin
                if (!rstn_i) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= sig_i;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    edge_mode_e        mode;
    logic              f_q, f_d;
    logic [FILT_W-1:0] fcnt_q, fcnt_d;
    logic              commit, qual;
    logic              sticky_q, sticky_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign mode = edge_mode_e'(mode_i);

    always_comb begin
        f_d    = f_q;
        fcnt_d = fcnt_q;
        commit = 1'b0;
        // During startup the filter simply adopts the input so pre-reset levels never look like edges.
        if (suppress_i) begin
            f_d    = s;
            fcnt_d = '0;
        end else if (s != f_q) begin
            if (fcnt_q >= filt_len_i) begin
                commit = 1'b1;
                f_d    = s;
                fcnt_d = '0;
            end else if (fcnt_q != '1) begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end else begin
            fcnt_d = '0;
        end

        qual = commit & ((s  & (mode == EDGE_RISE || mode == EDGE_BOTH)) |
                         (!s & (mode == EDGE_FALL || mode == EDGE_BOTH)));

        sticky_d = (sticky_q & ~clr_i) | qual;

        cnt_d = cnt_q;
        if (cnt_clr_i)                  cnt_d = qual ? CNT_W'(1) : '0;
        else if (qual && cnt_q != '1)   cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            f_q      <= 1'b0;
            fcnt_q   <= '0;
            pulse_o  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            f_q      <= f_d;
            fcnt_q   <= fcnt_d;
            pulse_o  <= qual;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sticky_o = sticky_q;
    assign count_o  = cnt_q;

endmodule

// File: rtl/edge_event_capture.sv
// Multi-channel edge event capture with startup suppression and a masked,
// registered interrupt.
module edge_event_capture
    import edge_cap_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_W      = DEF_FILT_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                    i_clk_ahb,
    input  logic                    i_rstn_ahb,
    input  logic [NUM_CH-1:0]       i_sig,
    input  logic [2*NUM_CH-1:0]     i_mode,
    input  logic [FILT_W-1:0]       i_filt_len,
    input  logic [NUM_CH-1:0]       i_irq_en,
    input  logic [NUM_CH-1:0]       i_clr,
    input  logic                    i_cnt_clr,
    output logic [NUM_CH-1:0]       o_pulse,
    output logic [NUM_CH-1:0]       o_sticky,
    output logic [NUM_CH*CNT_W-1:0] o_count,
    output logic                    o_irq
);

    // Suppression covers the synchroniser flush plus the first filter load.
    localparam int SUP_N = SYNC_STAGES + 1;
    localparam int SUP_W = $clog2(SUP_N + 1);

    logic [SUP_W-1:0] sup_q, sup_d;
    logic             suppress;
    logic             irq_q;

    assign suppress = (sup_q != SUP_W'(SUP_N));
    assign sup_d    = suppress ? sup_q + SUP_W'(1) : sup_q;

    always_ff @(posedge i_clk_ahb) begin
        if (!i_rstn_ahb) begin
            sup_q <= '0;
            irq_q <= 1'b0;
        end else begin
            sup_q <= sup_d;
            irq_q <= |(o_sticky & i_irq_en);
        end
    end

    assign o_irq = irq_q;

    generate
        for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
            edge_cap_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILT_W      (FILT_W),
                .CNT_W       (CNT_W)
            ) u_chan (
                .clk_i      (i_clk_ahb),
                .rstn_i     (i_rstn_ahb),
                .sig_i      (i_sig[n]),
                .mode_i     (i_mode[2*n +: 2]),
                .filt_len_i (i_filt_len),
                .suppress_i (suppress),
                .clr_i      (i_clr[n]),
                .cnt_clr_i  (i_cnt_clr),
                .pulse_o    (o_pulse[n]),
                .sticky_o   (o_sticky[n]),
                .count_o    (o_count[CNT_W*n +: CNT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_edge_event_capture.sv
// Bench for edge_event_capture: cycle-accurate behavioural model plus
// directed scenarios with hand-computed expectations and a random phase.
module tb_edge_event_capture;

    localparam int NUM_CH = 4;
    localparam int SYNC   = 2;
    localparam int FILT_W = 4;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic [NUM_CH-1:0]       sig = '0;
    logic [2*NUM_CH-1:0]     mode = '0;
    logic [FILT_W-1:0]       flen = '0;
    logic [NUM_CH-1:0]       irq_en = '0;
    logic [NUM_CH-1:0]       clr = '0;
    logic                    cnt_clr = 1'b0;
    logic [NUM_CH-1:0]       pulse, sticky;
    logic [NUM_CH*CNT_W-1:0] count;
    logic                    irq;

    int n_cmp = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    edge_event_capture #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .FILT_W(FILT_W), .CNT_W(CNT_W)
    ) dut (
        .i_clk_ahb  (clk),
        .i_rstn_ahb (rstn),
        .i_sig      (sig),
        .i_mode     (mode),
        .i_filt_len (flen),
        .i_irq_en   (irq_en),
        .i_clr      (clr),
        .i_cnt_clr  (cnt_clr),
        .o_pulse    (pulse),
        .o_sticky   (sticky),
        .o_count    (count),
        .o_irq      (irq)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: input delayed by SYNC samples, filtered level commits once the
    // mismatch has lasted more than L consecutive cycles.
    logic [NUM_CH-1:0] hist[$];
    logic [NUM_CH-1:0] m_pulse, m_sticky, m_f;
    int                m_run[NUM_CH];
    int                m_cnt[NUM_CH];
    logic              m_irq;
    int                m_sup;

    task automatic model_step();
        logic [NUM_CH-1:0] s, q;
        if (!rstn) begin
            hist.delete();
            for (int i = 0; i < SYNC; i++) hist.push_back('0);
            m_pulse = '0; m_sticky = '0; m_f = '0; m_irq = 1'b0; m_sup = SYNC + 1;
            for (int c = 0; c < NUM_CH; c++) begin m_run[c] = 0; m_cnt[c] = 0; end
            return;
        end
        s = hist.pop_front();
        hist.push_back(sig);
        q = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (m_sup > 0) begin
                m_f[c] = s[c]; m_run[c] = 0;
            end else if (s[c] != m_f[c]) begin
                m_run[c]++;
                if (m_run[c] > int'(flen)) begin
                    m_f[c] = s[c]; m_run[c] = 0;
                    q[c] = s[c] ? mode[2*c] : mode[2*c+1];
                end
            end else begin
                m_run[c] = 0;
            end
        end
        if (m_sup > 0) m_sup--;
        m_irq    = |(m_sticky & irq_en);
        m_sticky = (m_sticky & ~clr) | q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cnt_clr)                       m_cnt[c] = int'(q[c]);
            else if (q[c] && m_cnt[c] < CMAX)  m_cnt[c]++;
        end
        m_pulse = q;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("pulse", pulse, m_pulse);
            chk("sticky", sticky, m_sticky);
            chk("irq", irq, m_irq);
            for (int c = 0; c < NUM_CH; c++)
                chk($sformatf("count%0d", c), count[CNT_W*c +: CNT_W], m_cnt[c]);
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // reset state
        step(3);
        cmp_en = 1'b1;
        chk("rst_pulse", pulse, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_count", count, 0);
        chk("rst_irq", irq, 0);

        // basic rise, ch0 mode 01, L=0
        rstn = 1'b1; mode = 8'h01; irq_en = 4'h1; flen = '0;
        step(10);
        sig[0] = 1'b1;
        step(1); chk("rise_e0_pulse", pulse[0], 0);
        step(1); chk("rise_e1_pulse", pulse[0], 0);
        step(1); chk("rise_e2_pulse", pulse[0], 1);
        chk("rise_sticky", sticky[0], 1);
        chk("rise_count", count[CNT_W-1:0], 1);
        chk("rise_irq_early", irq, 0);
        step(1); chk("rise_e3_pulse", pulse[0], 0);
        chk("rise_irq", irq, 1);

        // glitch filter, ch1 mode 11, L=3
        sig = '0; mode = 8'h0C; flen = 4'd3;
        step(8);
        clr = '1; cnt_clr = 1'b1; step(1); clr = '0; cnt_clr = 1'b0;
        sig[1] = 1'b1; step(3); sig[1] = 1'b0; step(10);
        chk("glitch3_count", count[CNT_W +: CNT_W], 0);
        chk("glitch3_sticky", sticky[1], 0);
        sig[1] = 1'b1; step(4); sig[1] = 1'b0; step(10);
        chk("pulse4_count", count[CNT_W +: CNT_W], 2);

        // modes 00/01/10/11 on ch0..3, 5 full periods
        mode = 8'hE4; flen = '0; cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
        for (int p = 0; p < 5; p++) begin
            sig = '1; step(3); sig = '0; step(3);
        end
        step(6);
        chk("mode00_count", count[0 +: CNT_W], 0);
        chk("mode01_count", count[CNT_W +: CNT_W], 5);
        chk("mode10_count", count[2*CNT_W +: CNT_W], 5);
        chk("mode11_count", count[3*CNT_W +: CNT_W], 10);
        for (int c = 0; c < NUM_CH; c++) chk($sformatf("model_f%0d", c), m_f[c], sig[c]);

        // clear priority on ch2
        mode = 8'h30; clr = '1; cnt_clr = 1'b1; step(1); clr = '0; cnt_clr = 1'b0;
        chk("clr_all_sticky", sticky, 0);
        chk("clr_all_count2", count[2*CNT_W +: CNT_W], 0);
        sig[2] = 1'b1; step(2); clr = 4'b0100; step(1); clr = '0;
        chk("set_beats_clr", sticky[2], 1);
        chk("set_clr_pulse", pulse[2], 1);
        sig[2] = 1'b0; step(2); cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
        chk("cntclr_with_edge", count[2*CNT_W +: CNT_W], 1);

        // saturation: ch3 mode 11 toggling every cycle
        mode = 8'hC0;
        for (int i = 0; i < 300; i++) begin sig[3] = ~sig[3]; step(1); end
        step(4);
        chk("saturate", count[3*CNT_W +: CNT_W], CMAX);

        // input high through reset gives no events
        mode = 8'hFF; irq_en = '1; sig = '1; rstn = 1'b0; step(2);
        chk("rst1_pulse", pulse, 0);
        chk("rst1_sticky", sticky, 0);
        chk("rst1_count", count, 0);
        chk("rst1_irq", irq, 0);
        rstn = 1'b1; step(12);
        chk("hold_hi_sticky", sticky, 0);
        chk("hold_hi_count", count, 0);

        // reset in the middle of a filter run
        sig = '0; step(12);
        flen = 4'd5; sig[1] = 1'b1; step(4);
        chk("pre_midrst_irq", irq, 1);
        rstn = 1'b0; step(1);
        chk("midrst_pulse", pulse, 0);
        chk("midrst_sticky", sticky, 0);
        chk("midrst_count", count, 0);
        chk("midrst_irq", irq, 0);
        rstn = 1'b1; step(20);
        chk("no_stale_count", count, 0);
        chk("no_stale_sticky", sticky, 0);

        // random phase
        flen = '0;
        for (int i = 0; i < 2500; i++) begin
            sig ^= NUM_CH'($urandom_range(0, 15)) & NUM_CH'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) mode = 8'($urandom);
            if ($urandom_range(0, 63) == 0) flen = FILT_W'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0) irq_en = NUM_CH'($urandom);
            clr     = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0;
            cnt_clr = ($urandom_range(0, 31) == 0);
            rstn    = ($urandom_range(0, 399) != 0);
            step(1);
        end
        rstn = 1'b1; clr = '0; cnt_clr = 1'b0;
        step(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
